context_switch_unit: RTL and testbench
======================================

Name: context_switch_unit

Overview:
- Downstream consumer of the interrupt/quantum controller's savePC and CSe pulses.
- Holds a per-process saved-PC table and a valid mask, and captures the running process's PC on savePC.
- On CSe, performs a round-robin scan, one table entry per clock, for the next runnable process.
- Delivers the selected PC and pid to the PC mux with a one-cycle load pulse.
- Pid 0 is the kernel; it has no table entry and is the fallback when no user process is runnable.

Parameters:
- PID_W, 3, pid width; NPROC = 2**PID_W table entries (pid 0 reserved for the kernel).
- PC_W, 32, program-counter width.
- KERNEL_PC, 0, PC loaded when the kernel (pid 0) is selected.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- savePC  in  1  one-cycle pulse: store pc_current into table[cur_pid].
- CSe  in  1  one-cycle pulse: start a context switch.
- pc_current  in  PC_W  PC of the running process, valid when savePC=1.
- create_en  in  1  mark create_pid runnable with start PC create_pc.
- create_pid  in  PID_W  pid to create.
- create_pc  in  PC_W  start PC for create_pid.
- kill_en  in  1  mark kill_pid not runnable.
- kill_pid  in  PID_W  pid to kill.
- next_pc  out  PC_W  PC to load; valid while pc_load=1, held afterwards.
- pc_load  out  1  one-cycle pulse: PC mux takes next_pc.
- cur_pid  out  PID_W  pid currently running.
- busy  out  1  scan in progress; high in SCAN and LOAD.
- valid_mask  out  NPROC  runnable bits; bit 0 always 0.

Behaviour:
- Reset, synchronous and active-high:
  - state IDLE; all outputs zero (cur_pid=0, next_pc=0, pc_load=0, busy=0, valid_mask=0).
  - All table entries 0; probe counter 0.
  - Reset asserted mid-scan aborts the scan; no pc_load is issued.
- Table writes (any state, same edge):
  - create_en with create_pid!=0: valid[create_pid]<=1 and table[create_pid]<=create_pc.
  - kill_en with kill_pid!=0: valid[kill_pid]<=0.
  - Pid 0 is ignored for both create and kill.
  - Create and kill of the same pid on the same edge: kill wins; the table PC is still written.
- savePC:
  - In IDLE only: table[cur_pid]<=pc_current, unless cur_pid==0 (no write).
  - Ignored in SCAN and LOAD.
  - savePC together with create_en on the same pid: create wins.
- FSM IDLE/SCAN/LOAD:
  - IDLE: CSe=1 -> SCAN with k<=1. CSe outside IDLE is ignored. savePC and CSe on the same edge: the save is performed and the scan starts.
  - SCAN, per cycle: probe p=(cur_pid+k) mod NPROC.
    - If p!=0 and valid[p] (value on that edge, so a create/kill in the same cycle is not seen until the next probe): sel<=p, go to LOAD.
    - Else if k==NPROC (p==cur_pid, nothing found): sel<=0, go to LOAD.
    - Else k<=k+1.
  - Minimum scan is 1 cycle; maximum is NPROC cycles.
  - On the transition into LOAD:
    - cur_pid<=sel.
    - next_pc<=(sel==0 ? KERNEL_PC : table[sel]).
    - pc_load<=1.
  - LOAD (exactly one cycle): pc_load<=0, return to IDLE.
- Latency: CSe sampled at edge E0; with the first probe hitting, pc_load is high in the cycle after E1; busy is high from after E0 until after E2.
- The current process is reselected only if it is still valid and no other pid is runnable.
- Killing cur_pid does not stop it running; it just will not be reselected.
- pc_load is never asserted outside LOAD.

Test Plan:
- Reset, create pid1 PC 0x100 and pid3 PC 0x300, CSe -> scan probes pids 1 (hit); pc_load one cycle, next_pc=0x100, cur_pid=1, busy high 2 cycles.
- cur_pid=1, pc_current=0x144, savePC, then CSe -> table[1]=0x144; selects pid3 (probes 2,3, 2 scan cycles), next_pc=0x300; next CSe wraps through 4..7, 0, 1 -> next_pc=0x144.
- Only pid5 valid, cur_pid=5, CSe -> 8 probes, reselects pid5 with its saved PC, pc_load after 8 scan cycles.
- No valid pids, CSe -> cur_pid=0, next_pc=KERNEL_PC; kill_en and create_en on pid0 leave valid_mask=0.
- During SCAN from cur_pid=1, create pid6 PC 0x600 while probe is at pid3 -> pid6 found later in the same scan, next_pc=0x600; second CSe while busy produces no extra pc_load.
- savePC and CSe on the same edge -> table updated and scan started; create and kill of pid2 on the same edge -> valid[2]=0; reset mid-SCAN -> no pc_load, all outputs 0.

Source files
------------

// File: rtl/context_switch_unit_if.sv
// Bundle between the interrupt/quantum controller, the process manager and the
// context switch unit; master drives the requests, slave is the switch unit.
interface context_switch_unit_if #(
  parameter int PID_W = 3,
  parameter int PC_W  = 32
);
  localparam int NPROC = 1 << PID_W;

  logic             savePC;
  logic             CSe;
  logic [PC_W-1:0]  pc_current;
  logic             create_en;
  logic [PID_W-1:0] create_pid;
  logic [PC_W-1:0]  create_pc;
  logic             kill_en;
  logic [PID_W-1:0] kill_pid;
  logic [PC_W-1:0]  next_pc;
  logic             pc_load;
  logic [PID_W-1:0] cur_pid;
  logic             busy;
  logic [NPROC-1:0] valid_mask;

  modport master (
    output savePC, CSe, pc_current, create_en, create_pid, create_pc, kill_en, kill_pid,
    input  next_pc, pc_load, cur_pid, busy, valid_mask
  );
  modport slave (
    input  savePC, CSe, pc_current, create_en, create_pid, create_pc, kill_en, kill_pid,
    output next_pc, pc_load, cur_pid, busy, valid_mask
  );
endinterface

// File: rtl/context_switch_unit.sv
// Saved-PC table plus round-robin scheduler: on CSe, probes one pid per clock
// after cur_pid and hands the winner's PC to the PC mux with a one-cycle pulse.
module context_switch_unit #(
  parameter int              PID_W     = 3,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] KERNEL_PC = '0
) (
  input logic                  clock,
  input logic                  reset,
  context_switch_unit_if.slave bus
);
  localparam int NPROC = 1 << PID_W;
  localparam logic [PID_W:0] K_LAST = (PID_W+1)'(NPROC);

  typedef enum logic [1:0] {IDLE, SCAN, LOAD} state_e;

  state_e                      state_q, state_d;
  logic [PID_W:0]              k_q, k_d;
  logic [PID_W-1:0]            cur_pid_q, cur_pid_d;
  logic [PC_W-1:0]             next_pc_q, next_pc_d;
  logic                        pc_load_q, pc_load_d;
  logic [NPROC-1:0]            valid_q, valid_d;
  logic [NPROC-1:0][PC_W-1:0]  table_q, table_d;

  logic [PID_W-1:0] probe, sel;
  logic             hit;

  // k wraps the low bits, so k==NPROC probes cur_pid itself as the last candidate
  assign probe = cur_pid_q + k_q[PID_W-1:0];
  assign hit   = (probe != '0) && valid_q[probe];
  assign sel   = hit ? probe : '0;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cur_pid_d = cur_pid_q;
    next_pc_d = next_pc_q;
    pc_load_d = 1'b0;
    valid_d   = valid_q;
    table_d   = table_q;

    // order matters: save < create for the PC, create < kill for the valid bit
    if (state_q == IDLE && bus.savePC && cur_pid_q != '0)
      table_d[cur_pid_q] = bus.pc_current;
    if (bus.create_en && bus.create_pid != '0) begin
      valid_d[bus.create_pid] = 1'b1;
      table_d[bus.create_pid] = bus.create_pc;
    end
    if (bus.kill_en && bus.kill_pid != '0)
      valid_d[bus.kill_pid] = 1'b0;

    unique case (state_q)
      IDLE: if (bus.CSe) begin
        state_d = SCAN;
        k_d     = (PID_W+1)'(1);
      end
      SCAN: begin
        if (hit || k_q == K_LAST) begin
          state_d   = LOAD;
          cur_pid_d = sel;
          next_pc_d = (sel == '0) ? KERNEL_PC : table_q[sel];
          pc_load_d = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      LOAD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cur_pid_q <= '0;
      next_pc_q <= '0;
      pc_load_q <= 1'b0;
      valid_q   <= '0;
      table_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cur_pid_q <= cur_pid_d;
      next_pc_q <= next_pc_d;
      pc_load_q <= pc_load_d;
      valid_q   <= valid_d;
      table_q   <= table_d;
    end
  end

  assign bus.next_pc    = next_pc_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.cur_pid    = cur_pid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.valid_mask = valid_q;
endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit: scan lengths, selected PC/pid,
// table save/create/kill priority, kernel fallback and reset abort.
module tb_context_switch_unit;
  localparam int          PID_W = 3;
  localparam int          PC_W  = 32;
  localparam logic [31:0] KPC   = 32'h0000_0F00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  context_switch_unit_if #(.PID_W(PID_W), .PC_W(PC_W)) bus ();

  context_switch_unit #(.PID_W(PID_W), .PC_W(PC_W), .KERNEL_PC(KPC)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic create(input logic [2:0] pid, input logic [31:0] pc);
    bus.create_en = 1'b1; bus.create_pid = pid; bus.create_pc = pc;
    tick();
    bus.create_en = 1'b0;
  endtask

  task automatic kill(input logic [2:0] pid);
    bus.kill_en = 1'b1; bus.kill_pid = pid;
    tick();
    bus.kill_en = 1'b0;
  endtask

  // pulses CSe and returns the number of scan edges until pc_load, -1 on timeout
  task automatic run_switch(output int cyc);
    bus.CSe = 1'b1;
    tick();
    bus.CSe = 1'b0;
    cyc = 0;
    forever begin
      tick();
      cyc++;
      if (bus.pc_load) break;
      if (cyc >= 20) begin cyc = -1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.cur_pid !== 3'd0) begin errors++; $display("FAIL reset_cur_pid got %0h exp 0", bus.cur_pid); end
    checks++; if (bus.next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc got %0h exp 0", bus.next_pc); end
    checks++; if (bus.pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got %0b exp 0", bus.pc_load); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.valid_mask !== 8'h00) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.valid_mask); end
  endtask

  task automatic test_first_switch();
    create(3'd1, 32'h100);
    create(3'd3, 32'h300);
    checks++; if (bus.valid_mask !== 8'b0000_1010) begin errors++; $display("FAIL create_valid got %0h exp 0a", bus.valid_mask); end
    bus.CSe = 1'b1;
    tick();                                   // E0
    bus.CSe = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.pc_load !== 1'b0) begin errors++; $display("FAIL e0_busy got %0b/%0b exp 1/0", bus.busy, bus.pc_load); end
    tick();                                   // E1: probe pid1 hits
    checks++; if (bus.pc_load !== 1'b1) begin errors++; $display("FAIL e1_pc_load got %0b exp 1", bus.pc_load); end
    checks++; if (bus.next_pc !== 32'h100) begin errors++; $display("FAIL e1_next_pc got %0h exp 100", bus.next_pc); end
    checks++; if (bus.cur_pid !== 3'd1) begin errors++; $display("FAIL e1_cur_pid got %0h exp 1", bus.cur_pid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL e1_busy got %0b exp 1", bus.busy); end
    tick();                                   // E2: back to IDLE
    checks++; if (bus.pc_load !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL e2_idle got %0b/%0b exp 0/0", bus.pc_load, bus.busy); end
    checks++; if (bus.next_pc !== 32'h100) begin errors++; $display("FAIL e2_next_pc_held got %0h exp 100", bus.next_pc); end
  endtask

  task automatic test_save_wrap();
    int cyc;
    bus.savePC = 1'b1; bus.pc_current = 32'h144;
    tick();
    bus.savePC = 1'b0;
    run_switch(cyc);                          // from 1: probes 2,3
    checks++; if (cyc !== 2) begin errors++; $display("FAIL to3_cycles got %0d exp 2", cyc); end
    checks++; if (bus.next_pc !== 32'h300 || bus.cur_pid !== 3'd3) begin errors++; $display("FAIL to3_sel got %0h/%0h exp 300/3", bus.next_pc, bus.cur_pid); end
    tick();
    run_switch(cyc);                          // from 3: probes 4..7,0,1
    checks++; if (cyc !== 6) begin errors++; $display("FAIL wrap_cycles got %0d exp 6", cyc); end
    checks++; if (bus.next_pc !== 32'h144 || bus.cur_pid !== 3'd1) begin errors++; $display("FAIL wrap_sel got %0h/%0h exp 144/1", bus.next_pc, bus.cur_pid); end
    tick();
    checks++; if (bus.pc_load !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_idle got %0b/%0b exp 0/0", bus.pc_load, bus.busy); end
  endtask

  task automatic test_single();
    int cyc;
    kill(3'd1);
    kill(3'd3);
    create(3'd5, 32'h500);
    checks++; if (bus.valid_mask !== 8'b0010_0000) begin errors++; $display("FAIL single_valid got %0h exp 20", bus.valid_mask); end
    run_switch(cyc);                          // killed pid1 keeps running; from 1: probes 2..5
    checks++; if (cyc !== 4 || bus.cur_pid !== 3'd5) begin errors++; $display("FAIL to5 got cyc %0d pid %0h exp 4/5", cyc, bus.cur_pid); end
    tick();
    bus.savePC = 1'b1; bus.pc_current = 32'h5A0;
    tick();
    bus.savePC = 1'b0;
    run_switch(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL reselect_cycles got %0d exp 8", cyc); end
    checks++; if (bus.next_pc !== 32'h5A0 || bus.cur_pid !== 3'd5) begin errors++; $display("FAIL reselect_sel got %0h/%0h exp 5a0/5", bus.next_pc, bus.cur_pid); end
    tick();
  endtask

  task automatic test_kernel();
    int cyc;
    kill(3'd5);
    run_switch(cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL kernel_cycles got %0d exp 8", cyc); end
    checks++; if (bus.next_pc !== KPC || bus.cur_pid !== 3'd0) begin errors++; $display("FAIL kernel_sel got %0h/%0h exp f00/0", bus.next_pc, bus.cur_pid); end
    tick();
    create(3'd0, 32'h999);
    checks++; if (bus.valid_mask !== 8'h00) begin errors++; $display("FAIL create_pid0 got %0h exp 0", bus.valid_mask); end
    create(3'd2, 32'h200);
    kill(3'd0);
    checks++; if (bus.valid_mask !== 8'b0000_0100) begin errors++; $display("FAIL kill_pid0 got %0h exp 04", bus.valid_mask); end
    kill(3'd2);
  endtask

  task automatic test_mid_scan_create();
    int cyc, loads, first;
    create(3'd1, 32'h100);
    run_switch(cyc);
    checks++; if (cyc !== 1 || bus.cur_pid !== 3'd1) begin errors++; $display("FAIL from0 got cyc %0d pid %0h exp 1/1", cyc, bus.cur_pid); end
    tick();
    bus.CSe = 1'b1;
    tick();                                   // E0
    bus.CSe = 1'b0;
    tick();                                   // E1 probes 2
    bus.CSe = 1'b1;                           // ignored while busy
    bus.create_en = 1'b1; bus.create_pid = 3'd6; bus.create_pc = 32'h600;
    tick();                                   // E2 probes 3, pid6 created
    bus.CSe = 1'b0; bus.create_en = 1'b0;
    loads = 0; first = -1;
    for (int i = 3; i < 16; i++) begin
      tick();
      if (bus.pc_load) begin
        loads++;
        if (first < 0) begin
          first = i;
          checks++; if (bus.next_pc !== 32'h600 || bus.cur_pid !== 3'd6) begin errors++; $display("FAIL midscan_sel got %0h/%0h exp 600/6", bus.next_pc, bus.cur_pid); end
        end
      end
    end
    checks++; if (first !== 5) begin errors++; $display("FAIL midscan_cycles got %0d exp 5", first); end
    checks++; if (loads !== 1) begin errors++; $display("FAIL busy_cse_loads got %0d exp 1", loads); end
  endtask

  task automatic test_same_edge();
    int cyc;
    bus.savePC = 1'b1; bus.pc_current = 32'h6AA;
    run_switch(cyc);                          // save and CSe together; from 6: probes 7,0,1
    bus.savePC = 1'b0;
    checks++; if (cyc !== 3 || bus.next_pc !== 32'h100) begin errors++; $display("FAIL save_cse got cyc %0d pc %0h exp 3/100", cyc, bus.next_pc); end
    tick();
    run_switch(cyc);                          // from 1: probes 2..6
    checks++; if (cyc !== 5 || bus.next_pc !== 32'h6AA) begin errors++; $display("FAIL saved6 got cyc %0d pc %0h exp 5/6aa", cyc, bus.next_pc); end
    tick();
    bus.create_en = 1'b1; bus.create_pid = 3'd2; bus.create_pc = 32'h222;
    bus.kill_en = 1'b1; bus.kill_pid = 3'd2;
    tick();
    bus.create_en = 1'b0; bus.kill_en = 1'b0;
    checks++; if (bus.valid_mask !== 8'b0100_0010) begin errors++; $display("FAIL create_kill got %0h exp 42", bus.valid_mask); end
  endtask

  task automatic test_reset_mid_scan();
    int loads;
    bus.CSe = 1'b1;
    tick();                                   // E0
    bus.CSe = 1'b0;
    tick();                                   // probing pid7
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.pc_load !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_scan_ctl got %0b/%0b exp 0/0", bus.pc_load, bus.busy); end
    checks++; if (bus.cur_pid !== 3'd0 || bus.next_pc !== 32'h0 || bus.valid_mask !== 8'h00) begin errors++; $display("FAIL rst_scan_out got %0h/%0h/%0h exp 0/0/0", bus.cur_pid, bus.next_pc, bus.valid_mask); end
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pc_load) loads++;
    end
    checks++; if (loads !== 0) begin errors++; $display("FAIL rst_scan_loads got %0d exp 0", loads); end
  endtask

  initial begin
    bus.savePC = 1'b0; bus.CSe = 1'b0; bus.pc_current = '0;
    bus.create_en = 1'b0; bus.create_pid = '0; bus.create_pc = '0;
    bus.kill_en = 1'b0; bus.kill_pid = '0;
    test_reset();
    test_first_switch();
    test_save_wrap();
    test_single();
    test_kernel();
    test_mid_scan_create();
    test_same_edge();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
